imem_boot_controller: RTL
=========================

IMEM_BOOT_CONTROLLER -- requirements
Module: imem_boot_controller

Interface
REQ-001 The block SHALL take parameter addWidth, default 6, as the instruction memory address width in words.
REQ-002 The block SHALL take parameter dataWidth, default 32, as the instruction word width; byte assembly SHALL assume dataWidth = 32.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 boot_start  in  1  single-cycle pulse that requests a program (re)load.
REQ-007 rx_valid  in  1  loader byte-stream valid.
REQ-008 rx_byte  in  8  loader byte-stream data.
REQ-009 rx_ready  out  1  byte accepted when rx_valid & rx_ready are both high at a rising edge.
REQ-010 pc_addr  in  addWidth  fetch address from the PC.
REQ-011 fetch_instr  out  dataWidth  instruction delivered to the decoder.
REQ-012 imem_addr  out  addWidth  shared instruction memory address.
REQ-013 imem_wdata  out  dataWidth  memory write data.
REQ-014 imem_we  out  1  memory write enable, sampled by the memory on the rising edge.
REQ-015 imem_rdata  in  dataWidth  memory asynchronous read data.
REQ-016 cpu_run  out  1  high only while the CPU may execute.
REQ-017 boot_error  out  1  high while in ERR.

Function
REQ-018 The FSM SHALL have states IDLE, HDR, LOAD, WRITE, RUN and ERR.
REQ-019 IDLE: boot_start -> HDR; otherwise hold.
REQ-020 HDR: rx_ready = 1; an accepted byte N latches as word count; N = 0 or N > 2**addWidth -> ERR; otherwise -> LOAD with word index 0 and byte count 0.
REQ-021 LOAD: rx_ready = 1; accepted bytes SHALL shift in MSB first (first byte -> bits 31:24); the 4th accepted byte -> WRITE.
REQ-022 WRITE: rx_ready = 0, imem_we = 1, imem_addr = word index, imem_wdata = assembled word, for exactly one cycle; then the word index SHALL increment and the FSM SHALL go to RUN if the index reaches N, else to LOAD.
REQ-023 RUN: cpu_run = 1, imem_addr = pc_addr combinationally, fetch_instr = imem_rdata combinationally (zero added latency), imem_we = 0.
REQ-024 In all states other than RUN, fetch_instr SHALL be 0 (NOP) and cpu_run SHALL be 0.
REQ-025 boot_start in RUN or ERR SHALL go to HDR in the next cycle; cpu_run SHALL drop in that same cycle.
REQ-026 boot_start in HDR, LOAD or WRITE SHALL be ignored.
REQ-027 Outside HDR and LOAD, rx_valid SHALL be ignored and no byte SHALL be consumed.
REQ-028 The word index SHALL be addWidth+1 bits wide so that N = 2**addWidth loads all addresses without wrap.
REQ-029 When not in WRITE or RUN, imem_addr SHALL be the current word index (low addWidth bits) and imem_we = 0.
REQ-030 ERR: boot_error = 1, rx_ready = 0; exit only via boot_start or reset.

Reset
REQ-031 Reset SHALL force IDLE and clear the word index, byte count, word count and assembly register.
REQ-032 Reset SHALL force rx_ready = 0, imem_we = 0, cpu_run = 0, boot_error = 0 and fetch_instr = 0.
REQ-033 Reset SHALL take priority over every other input in any state, including mid-load; memory contents already written SHALL be left untouched.

Structure
REQ-034 A shared package SHALL hold the state encoding enum and the byte-per-word constant (4).
REQ-035 One sub-module, imem_word_assembler (byte shift register plus byte counter with a word_ready pulse), is natural and SHALL be used.
REQ-036 The FSM, word index and output muxing SHALL reside in imem_boot_controller.

Verification
REQ-037 Reset, boot_start, bytes 02, 12 34 56 78, 9A BC DE F0 -> writes 0x12345678 @0 and 0x9ABCDEF0 @1, each with a single imem_we pulse; cpu_run rises in the cycle after the second WRITE.
REQ-038 In RUN, set pc_addr = 1 with memory holding 0x9ABCDEF0 there -> fetch_instr = 0x9ABCDEF0 in the same cycle.
REQ-039 Header byte 00, then header byte 41 (65) in a separate boot -> ERR, boot_error = 1, no imem_we; boot_start -> HDR and boot_error = 0.
REQ-040 Header 40 (64) followed by 256 bytes -> addresses 0..63 written once each with no wrap; then RUN.
REQ-041 Reset asserted after 2 data bytes of a load -> next cycle IDLE, all outputs at reset values, no further writes; rx_valid held high causes no byte acceptance.
REQ-042 boot_start pulsed in RUN -> cpu_run = 0 and fetch_instr = 0 the next cycle; boot_start pulsed again during LOAD -> ignored and the load completes normally.

Source files
------------

// File: rtl/imem_boot_controller_pkg.sv
// rtl/imem_boot_controller_pkg.sv - shared state encoding and constants for the imem boot loader
package imem_boot_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } boot_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - MSB-first byte shift register with a word_ready pulse on the last byte
module imem_word_assembler
  import imem_boot_controller_pkg::*;
#(
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  output logic [dataWidth-1:0] word,
  output logic                 word_ready
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] byte_cnt;

  // Fires in the same cycle the final byte is presented, so the FSM enters WRITE as it lands.
  assign word_ready = byte_valid && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (byte_valid) begin
      word     <= {word[dataWidth-9:0], byte_in};
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_boot_controller.sv
// rtl/imem_boot_controller.sv - loads a byte-streamed program into instruction memory, then hands it to the CPU
module imem_boot_controller
  import imem_boot_controller_pkg::*;
#(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 boot_start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 rx_ready,
  input  logic [addWidth-1:0]  pc_addr,
  output logic [dataWidth-1:0] fetch_instr,
  output logic [addWidth-1:0]  imem_addr,
  output logic [dataWidth-1:0] imem_wdata,
  output logic                 imem_we,
  input  logic [dataWidth-1:0] imem_rdata,
  output logic                 cpu_run,
  output logic                 boot_error
);

  localparam int          IDX_W     = addWidth + 1;
  localparam logic [31:0] MAX_WORDS = 32'd1 << addWidth;

  boot_state_t          state;
  logic [IDX_W-1:0]     word_idx;
  logic [IDX_W-1:0]     word_idx_nxt;
  logic [7:0]           word_cnt;
  logic                 accept;
  logic                 hdr_ok;
  logic                 asm_clear;
  logic                 asm_valid;
  logic                 word_ready;
  logic [dataWidth-1:0] asm_word;

  assign accept       = rx_valid && rx_ready;
  assign hdr_ok       = (rx_byte != 8'd0) && ({24'd0, rx_byte} <= MAX_WORDS);
  assign asm_clear    = (state == S_HDR) && accept;
  assign asm_valid    = (state == S_LOAD) && accept;
  assign word_idx_nxt = word_idx + IDX_W'(1);

  imem_word_assembler #(
    .dataWidth (dataWidth)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_byte),
    .word       (asm_word),
    .word_ready (word_ready)
  );

  // RUN hands the memory port to the PC with no added latency.
  assign imem_addr   = (state == S_RUN) ? pc_addr : word_idx[addWidth-1:0];
  assign imem_wdata  = asm_word;
  assign fetch_instr = (state == S_RUN) ? imem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      word_idx   <= '0;
      word_cnt   <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      cpu_run    <= 1'b0;
      boot_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (boot_start) begin
            state    <= S_HDR;
            rx_ready <= 1'b1;
          end
        end
        S_HDR: begin
          if (accept) begin
            word_cnt <= rx_byte;
            if (hdr_ok) begin
              state    <= S_LOAD;
              word_idx <= '0;
            end else begin
              state      <= S_ERR;
              rx_ready   <= 1'b0;
              boot_error <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (word_ready) begin
            state    <= S_WRITE;
            rx_ready <= 1'b0;
            imem_we  <= 1'b1;
          end
        end
        S_WRITE: begin
          imem_we  <= 1'b0;
          word_idx <= word_idx_nxt;
          if ({{(32-IDX_W){1'b0}}, word_idx_nxt} == {24'd0, word_cnt}) begin
            state   <= S_RUN;
            cpu_run <= 1'b1;
          end else begin
            state    <= S_LOAD;
            rx_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (boot_start) begin
            state    <= S_HDR;
            cpu_run  <= 1'b0;
            rx_ready <= 1'b1;
          end
        end
        S_ERR: begin
          if (boot_start) begin
            state      <= S_HDR;
            boot_error <= 1'b0;
            rx_ready   <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          rx_ready   <= 1'b0;
          imem_we    <= 1'b0;
          cpu_run    <= 1'b0;
          boot_error <= 1'b0;
        end
      endcase
    end
  end

endmodule
